// File: rtl/bw_pkg.sv
// Shared definitions for the sequential Baugh-Wooley multiplier.
//   bw_state_t : controller states (IDLE, CALC, DONE)
//   bw_corr()  : signed-mode accumulator seed for a given operand width.
package bw_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } bw_state_t;

  // Baugh-Wooley correction constant 2^width + 2^(2*width-1), returned in
  // 64 bits. Callers keep the low 2*width bits, which applies the mod.
  function automatic logic [63:0] bw_corr(input int unsigned width);
    logic [63:0] c;
    c = (64'd1 << width) | (64'd1 << (2 * width - 1));
    return c;
  endfunction

endpackage

// File: rtl/bw_row_gen.sv
// One Baugh-Wooley partial-product row.
//   a_i           : latched multiplicand
//   b_bit_i       : multiplier bit selecting this row
//   last_row_i    : row is the multiplier sign row (i == WIDTH-1)
//   signed_mode_i : 1 = two's complement operands
//   row_o         : WIDTH+1 bit row, zero-extended (top bit always 0)
module bw_row_gen
  import bw_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic             b_bit_i,
  input  logic             last_row_i,
  input  logic             signed_mode_i,
  output logic [WIDTH:0]   row_o
);

  // In signed mode exactly the cross terms (one sign bit, one magnitude bit)
  // are inverted: bit WIDTH-1 on ordinary rows, bits below WIDTH-1 on the
  // last row. The sign*sign term on the last row stays positive.
  always_comb begin
    row_o = '0;
    for (int j = 0; j < WIDTH; j++) begin
      row_o[j] = (a_i[j] & b_bit_i) ^
                 (signed_mode_i & ((j == WIDTH - 1) ^ last_row_i));
    end
  end

endmodule

// File: rtl/bw_seq_mult.sv
// Sequential Baugh-Wooley multiplier, one partial-product row per clock.
// Ports:
//   clk, rst_n              : clock (rising edge), async active-low reset
//   in_valid / in_ready     : operand handshake (a, b, signed_mode)
//   out_valid / out_ready   : result handshake (p, 2*WIDTH bits)
//   busy                    : high while in CALC
//   dbg_state               : current controller state (bw_state_t encoding)
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. valid never waits on ready; once out_valid is high, p is held
// unchanged until the edge that sees out_ready high.
module bw_seq_mult
  import bw_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 signed_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   p,
  output logic                 busy,
  output logic [1:0]           dbg_state
);

  localparam logic [63:0]        CORR_FULL = bw_corr(WIDTH);
  localparam logic [2*WIDTH-1:0] CORR      = CORR_FULL[2*WIDTH-1:0];

  bw_state_t            state_q;
  logic [WIDTH-1:0]     a_q;
  logic [WIDTH-1:0]     b_q;
  logic                 sm_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [2*WIDTH-1:0]   acc_d;
  logic [2*WIDTH-1:0]   p_q;
  logic                 out_valid_q;
  logic [WIDTH:0]       row;
  logic [2*WIDTH-1:0]   row_sh;
  logic                 last_row;
  logic                 accept;

  assign last_row = (cnt_q == CNT_W'(WIDTH - 1));

  bw_row_gen #(.WIDTH(WIDTH)) u_row (
    .a_i           (a_q),
    .b_bit_i       (b_q[cnt_q]),
    .last_row_i    (last_row),
    .signed_mode_i (sm_q),
    .row_o         (row)
  );

  always_comb begin
    row_sh = {{(WIDTH - 1){1'b0}}, row} << cnt_q;
    acc_d  = acc_q + row_sh;
  end

  // A finished result may be replaced in the same cycle it is consumed.
  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign p         = p_q;
  assign busy      = (state_q == CALC);
  assign dbg_state = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sm_q        <= 1'b0;
      cnt_q       <= '0;
      acc_q       <= '0;
      p_q         <= '0;
      out_valid_q <= 1'b0;
    end else if (accept) begin
      // Accept is only possible in IDLE or DONE; any held result is consumed.
      a_q         <= a;
      b_q         <= b;
      sm_q        <= signed_mode;
      cnt_q       <= '0;
      acc_q       <= signed_mode ? CORR : '0;
      out_valid_q <= 1'b0;
      state_q     <= CALC;
    end else begin
      case (state_q)
        CALC: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 1'b1;
          if (last_row) begin
            p_q         <= acc_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bw_seq_mult.sv
module tb_bw_seq_mult;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- WIDTH=4 instance ----------------
  logic       in_valid4, in_ready4, sm4, out_valid4, out_ready4, busy4;
  logic [3:0] a4, b4;
  logic [7:0] p4;
  logic [1:0] st4;

  bw_seq_mult #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .signed_mode(sm4), .out_valid(out_valid4),
    .out_ready(out_ready4), .p(p4), .busy(busy4), .dbg_state(st4)
  );

  // ---------------- WIDTH=8 instance ----------------
  logic        in_valid8, in_ready8, sm8, out_valid8, out_ready8, busy8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;
  logic [1:0]  st8;

  bw_seq_mult #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .signed_mode(sm8), .out_valid(out_valid8),
    .out_ready(out_ready8), .p(p8), .busy(busy8), .dbg_state(st8)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference product: interpret operands as integers, multiply, wrap to 2w bits.
  function automatic longint ref_mul(input int w, input logic [15:0] a,
                                     input logic [15:0] b, input logic sm);
    longint sa, sb, r;
    sa = longint'(a);
    sb = longint'(b);
    if (sm && a[w-1]) sa = sa - (longint'(1) << w);
    if (sm && b[w-1]) sb = sb - (longint'(1) << w);
    r = sa * sb;
    return r & ((longint'(1) << (2 * w)) - 1);
  endfunction

  // ---------------- scoreboard for the WIDTH=4 instance ----------------
  logic [7:0] exp_q[$];
  int         acc_edge_q[$];
  logic       prev_v4 = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      acc_edge_q.delete();
      prev_v4 = 1'b0;
    end else begin
      if (out_valid4) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid4", longint'(out_valid4), 0);
        end else begin
          check("p4_scoreboard", p4, exp_q[0]);
          if (!prev_v4) check("latency4", cyc - acc_edge_q[0], 4);
          if (out_ready4) begin
            void'(exp_q.pop_front());
            void'(acc_edge_q.pop_front());
          end
        end
      end
      if (in_valid4 && in_ready4) begin
        exp_q.push_back(8'(ref_mul(4, 16'(a4), 16'(b4), sm4)));
        acc_edge_q.push_back(cyc + 1);
      end
      prev_v4 = out_valid4;
    end
  end

  // ---------------- driver tasks (WIDTH=4) ----------------
  // Entered and left at #1 after a rising edge.
  task automatic send4(input logic [3:0] a, input logic [3:0] b,
                       input logic sm, input bit rand_bp);
    int t = 0;
    a4 = a; b4 = b; sm4 = sm; in_valid4 = 1'b1;
    while (1) begin
      @(negedge clk);
      if (in_ready4) break;
      t++;
      if (t > 50) begin
        check("accept_timeout4", longint'(in_ready4), 1);
        break;
      end
      @(posedge clk); #1;
      if (rand_bp) out_ready4 = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    if (rand_bp) out_ready4 = ($urandom_range(0, 3) != 0);
  endtask

  // Returns at the negedge where out_valid4 is first seen, after checking p4.
  task automatic await4(input logic [7:0] exp, input string name);
    int t = 0;
    while (1) begin
      @(negedge clk);
      if (out_valid4) break;
      t++;
      if (t > 50) begin
        check("valid_timeout4", longint'(out_valid4), 1);
        break;
      end
    end
    check(name, p4, exp);
  endtask

  task automatic drain4();
    int t = 0;
    out_ready4 = 1'b1;
    while (exp_q.size() != 0 && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    check("drain4", exp_q.size(), 0);
  endtask

  // ---------------- driver task (WIDTH=8) ----------------
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic sm);
    int t = 0;
    int n = 0;
    a8 = a; b8 = b; sm8 = sm; in_valid8 = 1'b1;
    while (1) begin
      @(negedge clk);
      if (in_ready8) break;
      t++;
      if (t > 50) begin
        check("accept_timeout8", longint'(in_ready8), 1);
        break;
      end
    end
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    while (1) begin
      @(negedge clk);
      if (out_valid8) break;
      n++;
      if (n > 50) break;
    end
    check("latency8", n, 8);
    check("p8", p8, ref_mul(8, 16'(a), 16'(b), sm));
    @(posedge clk); #1;
  endtask

  // Directed vectors {a, b, signed_mode, expected p}, hand computed.
  logic [16:0] dv4 [10] = '{
    {4'hB, 4'hA, 1'b1, 8'h1E},  // -5 * -6  = 30
    {4'hB, 4'hA, 1'b0, 8'h6E},  // 11 * 10  = 110
    {4'hF, 4'hF, 1'b1, 8'h01},  // -1 * -1  = 1
    {4'hF, 4'hF, 1'b0, 8'hE1},  // 15 * 15  = 225
    {4'h7, 4'h9, 1'b1, 8'hCF},  //  7 * -7  = -49
    {4'h9, 4'h8, 1'b1, 8'h38},  // -7 * -8  = 56
    {4'h8, 4'h8, 1'b1, 8'h40},  // -8 * -8  = 64
    {4'h0, 4'h0, 1'b1, 8'h00},
    {4'h0, 4'h0, 1'b0, 8'h00},
    {4'h7, 4'h7, 1'b0, 8'h31}   //  7 * 7   = 49
  };

  // ---------------- main stimulus ----------------
  initial begin
    logic [16:0] v;
    logic [7:0]  corner8 [4] = '{8'h00, 8'h7F, 8'h80, 8'hFF};

    rst_n = 1'b0;
    in_valid4 = 1'b0; a4 = '0; b4 = '0; sm4 = 1'b0; out_ready4 = 1'b1;
    in_valid8 = 1'b0; a8 = '0; b8 = '0; sm8 = 1'b0; out_ready8 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", longint'(in_ready4), 1);
    check("rst_out_valid", longint'(out_valid4), 0);
    check("rst_p", p4, 0);
    check("rst_busy", longint'(busy4), 0);
    check("rst_state", st4, 0);
    check("rst_p8", p8, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Pin the reference model itself to hand-computed numbers.
    check("model_w8_s_min", ref_mul(8, 16'h80, 16'h80, 1'b1), 16'h4000);
    check("model_w8_u_max", ref_mul(8, 16'hFF, 16'hFF, 1'b0), 16'hFE01);

    // Directed vectors.
    for (int i = 0; i < 10; i++) begin
      v = dv4[i];
      check("model_pin4", ref_mul(4, 16'(v[16:13]), 16'(v[12:9]), v[8]), v[7:0]);
      send4(v[16:13], v[12:9], v[8], 1'b0);
      await4(v[7:0], "dir_p4");
      @(posedge clk); #1;
    end

    // Backpressure: result held for 10 cycles, then consumed with a new accept.
    out_ready4 = 1'b0;
    send4(4'h7, 4'h7, 1'b1, 1'b0);
    await4(8'h31, "bp_first_p");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_p_stable", p4, 8'h31);
      check("bp_valid_held", longint'(out_valid4), 1);
      check("bp_in_ready", longint'(in_ready4), 0);
      check("bp_busy", longint'(busy4), 0);
    end
    @(posedge clk); #1;
    a4 = 4'h3; b4 = 4'h5; sm4 = 1'b0; in_valid4 = 1'b1; out_ready4 = 1'b1;
    @(negedge clk);
    check("bp_release_in_ready", longint'(in_ready4), 1);
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    check("bp_valid_drops", longint'(out_valid4), 0);
    check("bp_new_busy", longint'(busy4), 1);
    await4(8'h0F, "bp_second_p");
    @(posedge clk); #1;

    // Back-to-back with out_ready held high.
    for (int i = 0; i < 5; i++)
      send4(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), 1'b0);
    drain4();

    // Reset two cycles into CALC discards the transaction.
    send4(4'h5, 4'h6, 1'b1, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("abort_in_ready", longint'(in_ready4), 1);
    check("abort_out_valid", longint'(out_valid4), 0);
    check("abort_p", p4, 0);
    check("abort_busy", longint'(busy4), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send4(4'h3, 4'hB, 1'b1, 1'b0);
    await4(8'hF1, "post_reset_p");
    @(posedge clk); #1;

    // Exhaustive WIDTH=4 sweep with random backpressure.
    for (int ia = 0; ia < 16; ia++)
      for (int ib = 0; ib < 16; ib++)
        for (int sm = 0; sm < 2; sm++)
          send4(4'(ia), 4'(ib), 1'(sm), 1'b1);
    drain4();

    // WIDTH=8: corners in both modes, then random operands.
    for (int ia = 0; ia < 4; ia++)
      for (int ib = 0; ib < 4; ib++)
        for (int sm = 0; sm < 2; sm++)
          run8(corner8[ia], corner8[ib], 1'(sm));
    for (int i = 0; i < 100; i++)
      run8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
           1'($urandom_range(0, 1)));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
